opcode_exec: RTL
================

Name: opcode_exec

Overview:
- Consumes the byte stream produced by the preamble/opcode detector: strobed 8-bit bytes, two per command frame (opcode byte, then argument byte).
- Decodes each command and updates the temperature-alarm configuration registers: high threshold, low threshold and alarm enable.
- Compares the live temperature sample against the thresholds and maintains a sticky alarm.
- Sits between the frame detector and the alarm/display logic of the temperature monitor.

Parameters:
- TH_HIGH_INIT, 8'd80: reset value of the high threshold.
- TH_LOW_INIT, 8'd10: reset value of the low threshold.
- TIMEOUT, 255: maximum number of cycles allowed between the opcode byte and the argument byte.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- din  input  8  command byte from the upstream detector.
- din_vld  input  1  one-cycle strobe; din is valid in that cycle.
- temp  input  8  unsigned temperature sample.
- temp_vld  input  1  one-cycle strobe; temp is valid in that cycle.
- th_high  output  8  current high threshold.
- th_low  output  8  current low threshold.
- alarm_en  output  1  alarm comparison enable.
- alarm  output  1  sticky alarm flag.
- cmd_done  output  1  one-cycle pulse: command executed.
- cmd_err  output  1  one-cycle pulse: command rejected or timed out.

Behaviour:
- Reset values: th_high=TH_HIGH_INIT, th_low=TH_LOW_INIT, alarm_en=0, alarm=0, cmd_done=0, cmd_err=0, FSM=IDLE, timeout counter=0.
- All outputs are registered.
- FSM has two states, IDLE and ARG.
- IDLE:
  - On din_vld, latch din into the opcode register, clear the timeout counter, go to ARG.
  - Otherwise stay.
- ARG:
  - On din_vld, execute {opcode, din} on that clock edge. Updated registers and the cmd_done/cmd_err pulse are visible the next cycle, i.e. one-cycle latency from the argument strobe. Return to IDLE.
  - Without din_vld, increment the counter. When the counter reaches TIMEOUT-1 without an argument byte: pulse cmd_err, drop the opcode, go to IDLE.
  - din_vld in the same cycle as the timeout: the byte wins and is treated as the argument.
- Opcode decode (arg = argument byte):
  - 0x01 set high threshold:
    - Accepted only if arg >= th_low. Then th_high<=arg and pulse cmd_done.
    - Otherwise registers are unchanged and cmd_err pulses.
  - 0x02 set low threshold:
    - Accepted only if arg <= th_high. Then th_low<=arg and pulse cmd_done.
    - Otherwise registers are unchanged and cmd_err pulses.
  - 0x03 enable: alarm_en<=arg[0], cmd_done. arg[7:1] are ignored.
  - 0x04 clear alarm: alarm<=0, cmd_done. The argument is ignored.
  - Any other opcode: cmd_err; no register changes.
- cmd_done and cmd_err are never high in the same cycle.
- Alarm:
  - Trip condition: alarm_en && temp_vld && (temp > th_high || temp < th_low).
  - Comparisons are unsigned 8-bit.
  - temp equal to a threshold does not trip.
  - alarm is sticky: set on trip, cleared only by opcode 0x04 or reset.
  - Trip in the same cycle as a 0x04 execution: alarm stays 1 (set wins).
  - The comparison uses the threshold and enable values held before any same-cycle command update.
- Disabling via 0x03 arg=0x00 does not clear an already-set alarm.
- Reset asserted mid-frame (FSM in ARG) returns the block to reset values immediately; the partial command is discarded.

Test Plan:
- Reset, then bytes 0x01, 0x5A (two cycles apart) -> one cycle after the 0x5A strobe: th_high=0x5A, cmd_done=1 for exactly one cycle, cmd_err=0.
- With th_high=0x50, send 0x02, 0x60 -> cmd_err pulse, th_low stays 10. Then send 0x02, 0x50 -> th_low=0x50, cmd_done (equality accepted).
- Send 0x03,0x01, then temp=0x51 with th_high=0x50 -> alarm=1 the cycle after temp_vld. Then temp=0x50 -> no trip. Then 0x04,0x00 -> alarm=0.
- Send 0x04 argument strobe in the same cycle as a tripping temp_vld -> alarm remains 1, cmd_done pulses.
- Send 0x01, then no byte for TIMEOUT cycles -> single cmd_err pulse, FSM in IDLE. A following 0x03,0x01 executes normally (alarm_en=1).
- Send opcode 0x7F,0x00 -> cmd_err, no register change. Assert rst_n low after a lone 0x01 -> all outputs at reset values. The next 0x02,0x05 sets th_low=5.

Source files
------------

// File: rtl/opcode_exec.sv
// Command executor for the temperature monitor: decodes opcode/argument
// frames into threshold/enable registers and keeps a sticky alarm.
module opcode_exec #(
  parameter logic [7:0] TH_HIGH_INIT = 8'd80,
  parameter logic [7:0] TH_LOW_INIT  = 8'd10,
  parameter int         TIMEOUT      = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_vld,
  input  logic [7:0] temp,
  input  logic       temp_vld,
  output logic [7:0] th_high,
  output logic [7:0] th_low,
  output logic       alarm_en,
  output logic       alarm,
  output logic       cmd_done,
  output logic       cmd_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ARG} state_t;

  state_t        state;
  logic [7:0]    opcode;
  logic [CW-1:0] cnt;
  logic          trip;

  // Trip uses pre-update thresholds/enable
  assign trip = alarm_en && temp_vld &&
                (temp > th_high || temp < th_low);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opcode   <= '0;
      cnt      <= '0;
      th_high  <= TH_HIGH_INIT;
      th_low   <= TH_LOW_INIT;
      alarm_en <= 1'b0;
      alarm    <= 1'b0;
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (din_vld) begin
            opcode <= din;
            cnt    <= '0;
            state  <= ARG;
          end
        end
        ARG: begin
          if (din_vld) begin
            state <= IDLE;
            unique case (opcode)
              8'h01: begin
                if (din >= th_low) begin
                  th_high  <= din;
                  cmd_done <= 1'b1;
                end else begin
                  cmd_err  <= 1'b1;
                end
              end
              8'h02: begin
                if (din <= th_high) begin
                  th_low   <= din;
                  cmd_done <= 1'b1;
                end else begin
                  cmd_err  <= 1'b1;
                end
              end
              8'h03: begin
                alarm_en <= din[0];
                cmd_done <= 1'b1;
              end
              8'h04: begin
                alarm    <= 1'b0;
                cmd_done <= 1'b1;
              end
              default: cmd_err <= 1'b1;
            endcase
          end else if (cnt == CNT_LAST) begin
            cmd_err <= 1'b1;
            opcode  <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Set wins over a same-cycle clear
      if (trip) alarm <= 1'b1;
    end
  end

endmodule
